// File: rtl/n64_pkg.sv
// Shared definitions for the N64 frame transmitter: FSM states, stop-bit
// selection and bit-cell durations expressed in microseconds.
package n64_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        BIT_LOW   = 3'd2,
        BIT_HIGH  = 3'd3,
        STOP_LOW  = 3'd4,
        STOP_HIGH = 3'd5
    } state_t;

    // Stop-bit flavour as sampled from stop_long
    localparam logic STOP_CONSOLE    = 1'b0;
    localparam logic STOP_CONTROLLER = 1'b1;

    // Durations in microseconds
    localparam logic [2:0] ZERO_LOW_US        = 3'd3;
    localparam logic [2:0] ONE_LOW_US         = 3'd1;
    localparam logic [2:0] CELL_US            = 3'd4;
    localparam logic [2:0] GUARD_US           = 3'd2;
    localparam logic [2:0] STOP_CONSOLE_US    = 3'd1;
    localparam logic [2:0] STOP_CONTROLLER_US = 3'd2;

    // Low time of a data cell for the given bit value
    function automatic logic [2:0] low_us(input logic b);
        return b ? ONE_LOW_US : ZERO_LOW_US;
    endfunction

    // High time of a data cell: the remainder of the 4us cell
    function automatic logic [2:0] high_us(input logic b);
        return CELL_US - low_us(b);
    endfunction

    // Low time of the stop bit
    function automatic logic [2:0] stop_low_us(input logic s);
        return (s == STOP_CONTROLLER) ? STOP_CONTROLLER_US : STOP_CONSOLE_US;
    endfunction

endpackage

// File: rtl/n64_us_timer.sv
// Load-and-count-down phase timer. Loading N microseconds makes expire rise
// in the N*US_TICKS-th cycle after the load, so a phase entered on the load
// edge lasts exactly N*US_TICKS cycles when the caller advances on expire.
module n64_us_timer
    import n64_pkg::*;
#(
    parameter int US_TICKS = 50
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       load,
    input  logic [2:0] load_us,
    output logic       expire
);

    localparam int CNT_W = $clog2(int'(CELL_US) * US_TICKS + 1);

    logic [CNT_W-1:0] count;

    // Reload on request, otherwise count down and hold at zero
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(load_us) * CNT_W'(US_TICKS) - CNT_W'(1);
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/n64_transmit_frame.sv
// N64 open-drain frame transmitter: shifts 1..MAX_BYTES bytes MSB first from a
// valid/ready stream through a one-byte prefetch buffer, then appends a
// console or controller stop bit. n64d_oe=1 pulls the data line low.
module n64_transmit_frame
    import n64_pkg::*;
#(
    parameter int US_TICKS  = 50,
    parameter int MAX_BYTES = 64,
    parameter int LEN_W     = 7
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] length,
    input  logic             stop_long,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             n64d_oe,
    output logic             busy,
    output logic             done,
    output logic             underrun
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

    state_t           state;
    state_t           state_n;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] accepted;
    logic             stop_q;
    logic [7:0]       buf_q;
    logic             buf_full;
    logic [7:0]       shifter;
    logic [2:0]       bit_idx;

    logic             tmr_load;
    logic [2:0]       tmr_us;
    logic             tmr_expire;

    logic             xfer;
    logic             take_buf;
    logic             take_in;
    logic             shift_bit;
    logic             start_frame;
    logic             zero_done;
    logic             end_ok;
    logic             end_under;

    // The buffer only asks for bytes that belong to the current frame
    assign data_ready = busy && !buf_full && (accepted < len_q);
    assign xfer       = data_valid && data_ready;

    n64_us_timer #(
        .US_TICKS (US_TICKS)
    ) u_timer (
        .sys_clk (sys_clk),
        .reset   (reset),
        .load    (tmr_load),
        .load_us (tmr_us),
        .expire  (tmr_expire)
    );

    // State register
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic and per-cycle control strobes
    always_comb begin
        state_n     = state;
        tmr_load    = 1'b0;
        tmr_us      = 3'd0;
        take_buf    = 1'b0;
        take_in     = 1'b0;
        shift_bit   = 1'b0;
        start_frame = 1'b0;
        zero_done   = 1'b0;
        end_ok      = 1'b0;
        end_under   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        zero_done = 1'b1;
                    end else begin
                        start_frame = 1'b1;
                        state_n     = FETCH;
                    end
                end
            end
            FETCH: begin
                if (buf_full) begin
                    take_buf = 1'b1;
                    tmr_load = 1'b1;
                    tmr_us   = low_us(buf_q[7]);
                    state_n  = BIT_LOW;
                end
            end
            BIT_LOW: begin
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    tmr_us   = high_us(shifter[7]);
                    state_n  = BIT_HIGH;
                end
            end
            BIT_HIGH: begin
                if (tmr_expire) begin
                    if (bit_idx != 3'd0) begin
                        shift_bit = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_us    = low_us(shifter[6]);
                        state_n   = BIT_LOW;
                    end else if (buf_full) begin
                        take_buf = 1'b1;
                        tmr_load = 1'b1;
                        tmr_us   = low_us(buf_q[7]);
                        state_n  = BIT_LOW;
                    end else if (accepted < len_q) begin
                        // A byte arriving exactly at the boundary goes straight
                        // to the shifter instead of being lost to an abort.
                        if (xfer) begin
                            take_in  = 1'b1;
                            tmr_load = 1'b1;
                            tmr_us   = low_us(data_in[7]);
                            state_n  = BIT_LOW;
                        end else begin
                            end_under = 1'b1;
                            state_n   = IDLE;
                        end
                    end else begin
                        tmr_load = 1'b1;
                        tmr_us   = stop_low_us(stop_q);
                        state_n  = STOP_LOW;
                    end
                end
            end
            STOP_LOW: begin
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    tmr_us   = GUARD_US;
                    state_n  = STOP_HIGH;
                end
            end
            STOP_HIGH: begin
                if (tmr_expire) begin
                    end_ok  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Control registers: line drive, status pulses, frame bookkeeping
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            n64d_oe  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
            len_q    <= '0;
            stop_q   <= STOP_CONSOLE;
            accepted <= '0;
            buf_full <= 1'b0;
            bit_idx  <= 3'd0;
        end else begin
            n64d_oe  <= (state_n == BIT_LOW) || (state_n == STOP_LOW);
            done     <= zero_done || end_ok;
            underrun <= end_under;

            if (start_frame) begin
                busy     <= 1'b1;
                len_q    <= (length > MAX_LEN) ? MAX_LEN : length;
                stop_q   <= stop_long;
                accepted <= '0;
            end else begin
                if (end_ok || end_under) begin
                    busy <= 1'b0;
                end
                if (xfer) begin
                    accepted <= accepted + LEN_W'(1);
                end
            end

            if (xfer && !take_in) begin
                buf_full <= 1'b1;
            end else if (take_buf) begin
                buf_full <= 1'b0;
            end

            if (take_buf || take_in) begin
                bit_idx <= 3'd7;
            end else if (shift_bit) begin
                bit_idx <= bit_idx - 3'd1;
            end
        end
    end

    // Data registers: prefetch buffer and output shifter
    always_ff @(posedge sys_clk) begin
        if (xfer && !take_in) begin
            buf_q <= data_in;
        end
        if (take_buf) begin
            shifter <= buf_q;
        end else if (take_in) begin
            shifter <= data_in;
        end else if (shift_bit) begin
            shifter <= {shifter[6:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_n64_transmit_frame.sv
// Bench for n64_transmit_frame with US_TICKS=4, MAX_BYTES=8.
module tb_n64_transmit_frame;

    localparam int U    = 4;
    localparam int MAXB = 8;
    localparam int LW   = 4;

    logic          sys_clk    = 1'b0;
    logic          reset      = 1'b1;
    logic          start      = 1'b0;
    logic [LW-1:0] length     = '0;
    logic          stop_long  = 1'b0;
    logic [7:0]    data_in    = 8'h00;
    logic          data_valid = 1'b0;
    logic          data_ready;
    logic          n64d_oe;
    logic          busy;
    logic          done;
    logic          underrun;

    int n_checks = 0;
    int n_fail   = 0;
    int xfers    = 0;

    typedef struct {
        int          len;
        bit          sl;
        logic [63:0] bytes;
        int          avail;
        int          busy_at;
        int          exp_under;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[6];

    always #5 sys_clk = ~sys_clk;

    n64_transmit_frame #(
        .US_TICKS  (U),
        .MAX_BYTES (MAXB),
        .LEN_W     (LW)
    ) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .start      (start),
        .length     (length),
        .stop_long  (stop_long),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .n64d_oe    (n64d_oe),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    // Count stream handshakes
    always @(negedge sys_clk) begin
        if (data_valid && data_ready) xfers <= xfers + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Streams n bytes with random idle gaps; optionally keeps offering a
    // surplus byte afterwards, which must never be taken.
    task automatic feed(input logic [63:0] bytes, input int n, input int gap_max,
                        input bit hold_extra);
        for (int i = 0; i < n; i++) begin
            int g;
            bit seen;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            data_valid = 1'b0;
            for (int j = 0; j < g; j++) begin
                @(posedge sys_clk);
                #1;
            end
            data_in    = bytes[63-8*i -: 8];
            data_valid = 1'b1;
            seen = 1'b0;
            for (int t = 0; t < 4000; t++) begin
                @(negedge sys_clk);
                if (data_ready) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("feed_handshake", int'(seen), 1);
            @(posedge sys_clk);
            #1;
            if (!seen) break;
        end
        data_in    = 8'hEE;
        data_valid = hold_extra;
    endtask

    // Runs one frame and compares the line against a cell-level model
    task automatic run_frame(input string tag, input int len, input bit sl,
                             input logic [63:0] bytes, input int avail,
                             input int gap_max, input int busy_at,
                             input int exp_under, input int exp_cycles);
        int eff, nb, lo, k, mism, base, L;
        bit under, rise;
        bit wave[$];
        logic [7:0] b;
        eff   = (len > MAXB) ? MAXB : len;
        under = (avail < eff);
        nb    = under ? avail : eff;
        for (int i = 0; i < nb; i++) begin
            b = bytes[63-8*i -: 8];
            for (int j = 7; j >= 0; j--) begin
                lo = b[j] ? U : 3 * U;
                for (int c = 0; c < lo; c++) wave.push_back(1'b1);
                for (int c = 0; c < 4 * U - lo; c++) wave.push_back(1'b0);
            end
        end
        if (!under) begin
            lo = sl ? 2 * U : U;
            for (int c = 0; c < lo; c++) wave.push_back(1'b1);
            for (int c = 0; c < 2 * U; c++) wave.push_back(1'b0);
        end
        L    = wave.size();
        base = xfers;

        data_valid = 1'b0;
        start      = 1'b1;
        length     = LW'(len);
        stop_long  = sl;
        @(posedge sys_clk);
        #1;
        start = 1'b0;
        fork
            feed(bytes, nb, gap_max, !under);
            begin
                if (busy_at > 0) begin
                    repeat (busy_at) @(posedge sys_clk);
                    #1;
                    start     = 1'b1;
                    length    = LW'(1);
                    stop_long = ~sl;
                    @(posedge sys_clk);
                    #1;
                    start = 1'b0;
                end
            end
            begin
                rise = 1'b0;
                for (int t = 0; t < 300; t++) begin
                    @(negedge sys_clk);
                    if (n64d_oe === 1'b1) begin
                        rise = 1'b1;
                        break;
                    end
                end
                check({tag, "_oe_rise"}, int'(rise), 1);
                if (rise) begin
                    check({tag, "_busy_in_frame"}, int'(busy), 1);
                    k    = 0;
                    mism = 0;
                    while (k < 3000 && !(done || underrun)) begin
                        if (k < L && n64d_oe !== wave[k]) mism++;
                        k++;
                        @(negedge sys_clk);
                    end
                    check({tag, "_wave_mismatches"}, mism, 0);
                    check({tag, "_frame_cycles"}, k, (exp_cycles >= 0) ? exp_cycles : L);
                    check({tag, "_underrun"}, int'(underrun),
                          (exp_under >= 0) ? exp_under : int'(under));
                    check({tag, "_done"}, int'(done),
                          (exp_under >= 0) ? 1 - exp_under : 1 - int'(under));
                    check({tag, "_busy_end"}, int'(busy), 0);
                    check({tag, "_oe_end"}, int'(n64d_oe), 0);
                    @(negedge sys_clk);
                    check({tag, "_pulse_width"}, int'(done | underrun), 0);
                end
            end
        join
        @(posedge sys_clk);
        #1;
        check({tag, "_transfers"}, xfers - base, nb);
        data_valid = 1'b0;
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rise;
        vecs[0] = '{1,  1'b0, 64'h0100000000000000, 1, 0,  0, 140};
        vecs[1] = '{3,  1'b0, 64'hFF00A50000000000, 3, 0,  0, 396};
        vecs[2] = '{2,  1'b0, 64'h5A3C000000000000, 1, 0,  1, 128};
        vecs[3] = '{1,  1'b1, 64'h8000000000000000, 1, 0,  0, 144};
        vecs[4] = '{2,  1'b1, 64'hC33C000000000000, 2, 40, 0, 272};
        vecs[5] = '{12, 1'b0, 64'h0123456789ABCDEF, 8, 0,  0, 1036};

        // Reset state
        @(negedge sys_clk);
        check("reset_oe", int'(n64d_oe), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_ready", int'(data_ready), 0);
        check("reset_done", int'(done), 0);
        check("reset_underrun", int'(underrun), 0);
        reset = 1'b0;
        @(posedge sys_clk);
        #1;

        // Zero-length request
        start  = 1'b1;
        length = '0;
        @(posedge sys_clk);
        #1;
        start = 1'b0;
        check("len0_done", int'(done), 1);
        check("len0_busy", int'(busy), 0);
        check("len0_oe", int'(n64d_oe), 0);
        @(posedge sys_clk);
        #1;
        check("len0_done_clear", int'(done), 0);
        rise = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            if (n64d_oe || busy) rise = 1'b1;
        end
        check("len0_idle_line", int'(rise), 0);
        @(posedge sys_clk);
        #1;

        // Table-driven frames
        for (int v = 0; v < 6; v++) begin
            run_frame($sformatf("vec%0d", v), vecs[v].len, vecs[v].sl, vecs[v].bytes,
                      vecs[v].avail, 0, vecs[v].busy_at, vecs[v].exp_under,
                      vecs[v].exp_cycles);
        end

        // Reset in the middle of a BIT_LOW phase
        data_in    = 8'h00;
        data_valid = 1'b1;
        start      = 1'b1;
        length     = LW'(1);
        stop_long  = 1'b0;
        @(posedge sys_clk);
        #1;
        start = 1'b0;
        rise  = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge sys_clk);
            if (n64d_oe === 1'b1) begin
                rise = 1'b1;
                break;
            end
        end
        check("rst_mid_oe_rise", int'(rise), 1);
        repeat (3) @(negedge sys_clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_oe", int'(n64d_oe), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_ready", int'(data_ready), 0);
        check("rst_mid_done", int'(done), 0);
        check("rst_mid_underrun", int'(underrun), 0);
        @(negedge sys_clk);
        reset      = 1'b0;
        data_valid = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_after_busy", int'(busy), 0);
        check("rst_after_done", int'(done), 0);
        run_frame("post_reset", 1, 1'b0, 64'hA500000000000000, 1, 0, 0, 0, 140);

        // Randomized frames against the cell model
        for (int r = 0; r < 6; r++) begin
            int len, eff, avail;
            bit sl;
            logic [63:0] bytes;
            len   = int'($urandom_range(9, 1));
            bytes = {$urandom, $urandom};
            sl    = 1'($urandom_range(1, 0));
            eff   = (len > MAXB) ? MAXB : len;
            avail = eff;
            if (eff > 1 && $urandom_range(3, 0) == 0) avail = int'($urandom_range(eff - 1, 1));
            run_frame($sformatf("rand%0d", r), len, sl, bytes, avail, 20, 0, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/n64_transmit_frame.md
Name: n64_transmit_frame

Overview:
- Parametrised successor to the single-byte N64 transmitter: serialises a frame of 1..MAX_BYTES bytes, MSB first, and ends it with a selectable stop bit.
- Bit-cell timing is generated internally from a microsecond tick count, so no separate bit-level block is needed.
- Bytes arrive on a valid/ready stream with a one-byte prefetch buffer, so bit cells run back to back across byte boundaries.
- Drives the open-drain N64 data line through an active-high pull-low enable. Sits between the controller/console protocol engine and the pad.

Parameters:
- US_TICKS, 50, sys_clk cycles per microsecond (must be >=2).
- MAX_BYTES, 64, maximum frame length in bytes.
- LEN_W, 7, width of the length input (must satisfy 2^LEN_W > MAX_BYTES).

Ports:
- sys_clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle frame request; ignored while busy
- length  in  LEN_W  byte count, sampled with start; valid range 0..MAX_BYTES
- stop_long  in  1  sampled with start; 0 = console stop (1us low), 1 = controller stop (2us low)
- data_in  in  8  stream byte
- data_valid  in  1  stream valid
- data_ready  out  1  stream ready; a byte transfers when valid && ready
- n64d_oe  out  1  1 = pull line low, 0 = release; registered output
- busy  out  1  high from the cycle after an accepted start until done/error
- done  out  1  one-cycle pulse at successful frame end
- underrun  out  1  one-cycle pulse when a frame aborts for lack of data

Behaviour:
- Reset (async, active-high): n64d_oe, busy, data_ready, done and underrun all go to 0 immediately. The buffer empties, counters clear, and the state goes to IDLE. Reset mid-frame releases the line at once, with no stop bit and no done pulse.
- Bit cell is 4*US_TICKS cycles:
  - '0' = 3*US_TICKS low, then US_TICKS high.
  - '1' = US_TICKS low, then 3*US_TICKS high.
- Stop bit:
  - console: US_TICKS low, then 2*US_TICKS high guard.
  - controller: 2*US_TICKS low, then 2*US_TICKS high guard.
- States: IDLE, FETCH, BIT_LOW, BIT_HIGH, STOP_LOW, STOP_HIGH.
- IDLE + start:
  - length==0: pulse done on the next cycle; busy stays 0 and the line is untouched.
  - length>MAX_BYTES: clamp to MAX_BYTES.
  - otherwise: latch length and stop_long, set busy, go to FETCH.
- FETCH waits indefinitely for the first byte. n64d_oe goes to 1 the cycle after the buffer fills, and state goes to BIT_LOW with shifter = buffer and bit index 7.
- data_ready = busy && buffer empty && bytes_accepted < latched length. It is never high in IDLE.
- The buffer refills while the current byte shifts out. At each byte boundary (end of BIT_HIGH of bit 0 with bytes remaining), the buffer loads into the shifter in the same cycle the next BIT_LOW begins. There is no gap cycle.
- If the buffer is empty at a byte boundary:
  - release the line (n64d_oe=0) and pulse underrun for one cycle;
  - clear busy and go to IDLE; no stop bit is sent.
- After the last bit's BIT_HIGH: STOP_LOW (n64d_oe=1), then STOP_HIGH (n64d_oe=0). done pulses on the cycle STOP_HIGH completes, busy clears in that same cycle, and state returns to IDLE.
- start while busy is ignored. Extra data_valid beyond length is not accepted.
- Total frame time is length*32*US_TICKS + (3 or 4)*US_TICKS cycles, measured from the first n64d_oe rise to done.

Decomposition:
- Shared package n64_pkg:
  - state enum;
  - stop-type constants (STOP_CONSOLE=0, STOP_CONTROLLER=1);
  - low/high duration multipliers in microseconds (ZERO_LOW_US=3, ONE_LOW_US=1, CELL_US=4, GUARD_US=2).
- One natural sub-module, n64_us_timer:
  - a load-and-count-down cycle counter that takes a microsecond count times US_TICKS;
  - produces an expire pulse;
  - shared by the bit and stop phases.

Test Plan:
- US_TICKS=4, length=1, byte 0x01, console stop:
  - response: seven cells of 12 low / 4 high, one cell of 4 low / 12 high, then 4 low / 8 high;
  - done pulses 140 cycles after the first oe rise, then busy=0.
- length=3 with bytes 0xFF, 0x00, 0xA5 presented with valid held high:
  - response: oe pattern continuous with no gap cycle at the byte boundaries; data_ready pulses exactly 3 times.
- length=2, second byte withheld:
  - response: after 32*US_TICKS of byte 1, oe=0 and underrun pulses once;
  - done never asserts; busy=0.
- length=1, 0x80, stop_long=1:
  - response: stop is 8 cycles low, then 8 cycles high; done pulses.
- reset asserted mid BIT_LOW:
  - response: oe=0 the same cycle (async) and all outputs are 0;
  - a new start after reset transmits correctly.
- length=0 start, and start asserted while busy:
  - length=0: done pulses next cycle with no oe activity;
  - start while busy: the frame in progress is unaffected.
